pipe_reg_chain: RTL and testbench



---
 rtl/pipe_reg_chain.sv | 134 +++++++++++++
 tb/tb_pipe_reg_chain.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Chain of DEPTH pipeline registers carrying a valid bit and a WIDTH-bit payload.
// Each stage can be held or killed independently, and every stage is tapped.

module pipe_reg_stage #(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
  parameter bit               FLUSH_ZERO    = 1'b1,
  parameter bit               HAS_SRC_STALL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             stall,
  input  logic             flush,
  input  logic             src_stall,
  output logic             valid_nxt,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             kill;
  logic [WIDTH-1:0] data_nxt;

  // A held upstream stage has nothing new to hand over, so this stage takes a bubble.
  assign kill = flush | (HAS_SRC_STALL & src_stall);

  always_comb begin
    valid_nxt = valid;
    data_nxt  = data;
    if (stall) begin
      valid_nxt = valid;
      data_nxt  = data;
    end else if (kill) begin
      valid_nxt = 1'b0;
      data_nxt  = FLUSH_ZERO ? RESET_VALUE : data;
    end else begin
      valid_nxt = src_valid;
      data_nxt  = src_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= RESET_VALUE;
    end else begin
      valid <= valid_nxt;
      data  <= data_nxt;
    end
  end

endmodule

module pipe_reg_chain #(
  parameter int               WIDTH       = 32,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               FLUSH_ZERO  = 1'b1,
  localparam int              OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  output logic [DEPTH-1:0]       out_valid,
  output logic [DEPTH*WIDTH-1:0] out_data,
  output logic [OCC_W-1:0]       occupancy,
  output logic                   stall_err
);

  logic [DEPTH-1:0]            vld, vld_d, src_v, src_stall;
  logic [DEPTH-1:0][WIDTH-1:0] dat, src_d;
  logic                        viol;
  logic [OCC_W-1:0]            occ_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign src_v[i]     = in_valid;
      assign src_d[i]     = in_data;
      assign src_stall[i] = 1'b0;
    end else begin : g_body
      assign src_v[i]     = vld[i-1];
      assign src_d[i]     = dat[i-1];
      assign src_stall[i] = stall[i-1];
    end

    pipe_reg_stage #(
      .WIDTH        (WIDTH),
      .RESET_VALUE  (RESET_VALUE),
      .FLUSH_ZERO   (FLUSH_ZERO),
      .HAS_SRC_STALL(i > 0)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .src_valid(src_v[i]),
      .src_data (src_d[i]),
      .stall    (stall[i]),
      .flush    (flush[i]),
      .src_stall(src_stall[i]),
      .valid_nxt(vld_d[i]),
      .valid    (vld[i]),
      .data     (dat[i])
    );
  end

  // Legal stall patterns are a contiguous run starting at stage 0.
  if (DEPTH > 1) begin : g_viol
    assign viol = |(stall[DEPTH-1:1] & ~stall[DEPTH-2:0]);
  end else begin : g_noviol
    assign viol = 1'b0;
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + OCC_W'(vld_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
      stall_err <= 1'b0;
    end else begin
      occupancy <= occ_d;
      if (viol) stall_err <= 1'b1;
    end
  end

  assign out_valid = vld;
  assign out_data  = dat;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain: a FLUSH_ZERO=1 instance and a FLUSH_ZERO=0
// instance with a non-zero reset value share the same stimulus.

module tb_pipe_reg_chain;
  localparam int W = 32;
  localparam int D = 3;
  localparam logic [W-1:0] RV_B = 32'hA5A5_0000;

  logic           clk = 1'b0;
  logic           rst, in_valid;
  logic [W-1:0]   in_data;
  logic [D-1:0]   stall, flush;
  logic [D-1:0]   va, vb;
  logic [D*W-1:0] da, db;
  logic [1:0]     occa, occb;
  logic           erra, errb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VALUE('0), .FLUSH_ZERO(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .stall(stall),
    .flush(flush), .out_valid(va), .out_data(da), .occupancy(occa), .stall_err(erra)
  );

  pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(RV_B), .FLUSH_ZERO(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .stall(stall),
    .flush(flush), .out_valid(vb), .out_data(db), .occupancy(occb), .stall_err(errb)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic iv, input logic [W-1:0] id,
                      input logic [D-1:0] st, input logic [D-1:0] fl);
    rst = r; in_valid = iv; in_data = id; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  // Check A: valid vector, stage data (s2,s1,s0), occupancy, error flag.
  task automatic chk_a(input string tag, input logic [D-1:0] v, input logic [D*W-1:0] d,
                       input logic [1:0] occ, input logic err);
    chk({tag, ".valid"}, 96'(va), 96'(v));
    chk({tag, ".data"}, 96'(da), 96'(d));
    chk({tag, ".occ"}, 96'(occa), 96'(occ));
    chk({tag, ".err"}, 96'(erra), 96'(err));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; stall = '0; flush = '0;
    step(1, 0, 0, 3'b000, 3'b000);
    step(1, 0, 0, 3'b000, 3'b000);
    chk_a("reset", 3'b000, '0, 2'd0, 1'b0);
    chk("reset.b_data", 96'(db), 96'({RV_B, RV_B, RV_B}));
    chk("reset.b_valid", 96'(vb), 96'(3'b000));

    // Fill
    step(0, 1, 32'h100, 3'b000, 3'b000);
    chk_a("fill1", 3'b001, {32'h0, 32'h0, 32'h100}, 2'd1, 1'b0);
    step(0, 1, 32'h104, 3'b000, 3'b000);
    chk_a("fill2", 3'b011, {32'h0, 32'h100, 32'h104}, 2'd2, 1'b0);
    step(0, 1, 32'h108, 3'b000, 3'b000);
    chk_a("fill3", 3'b111, {32'h100, 32'h104, 32'h108}, 2'd3, 1'b0);

    // Bubble: stage 0 holds, stage 1 gets a bubble, stage 2 advances
    step(0, 1, 32'h10C, 3'b001, 3'b000);
    chk_a("bubble", 3'b101, {32'h104, 32'h0, 32'h108}, 2'd2, 1'b0);
    chk("bubble.b_valid", 96'(vb), 96'(3'b101));
    chk("bubble.b_data", 96'(db), 96'({32'h104, 32'h104, 32'h108}));

    // Refill
    step(0, 1, 32'h10C, 3'b000, 3'b000);
    chk_a("refill1", 3'b011, {32'h0, 32'h108, 32'h10C}, 2'd2, 1'b0);
    step(0, 1, 32'hDEAD_BEEF, 3'b000, 3'b000);
    chk_a("refill2", 3'b111, {32'h108, 32'h10C, 32'hDEAD_BEEF}, 2'd3, 1'b0);

    // Stall beats flush on stages 0/1; stage 2 sees a held source and takes a bubble
    step(0, 1, 32'h114, 3'b011, 3'b011);
    chk_a("stall_flush", 3'b011, {32'h0, 32'h10C, 32'hDEAD_BEEF}, 2'd2, 1'b0);
    chk("stall_flush.b_data", 96'(db), 96'({32'h108, 32'h10C, 32'hDEAD_BEEF}));

    // Flush without stall kills stages 0/1; stage 2 loads stage 1
    step(0, 1, 32'h114, 3'b000, 3'b011);
    chk_a("flush", 3'b100, {32'h10C, 32'h0, 32'h0}, 2'd1, 1'b0);
    chk("flush.b_valid", 96'(vb), 96'(3'b100));
    chk("flush.b_data", 96'(db), 96'({32'h10C, 32'h10C, 32'hDEAD_BEEF}));

    step(0, 1, 32'h118, 3'b000, 3'b000);
    chk_a("post_flush", 3'b001, {32'h0, 32'h0, 32'h118}, 2'd1, 1'b0);

    // Illegal stall: stage 1 holds, stage 0 overwritten, stage 2 bubbled
    step(0, 1, 32'h120, 3'b010, 3'b000);
    chk_a("viol", 3'b001, {32'h0, 32'h0, 32'h120}, 2'd1, 1'b1);
    chk("viol.b_err", 96'(errb), 96'(1'b1));
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 32'h0, 3'b000, 3'b000);
      chk("viol.sticky", 96'(erra), 96'(1'b1));
    end
    chk_a("drained", 3'b000, '0, 2'd0, 1'b1);
    step(1, 0, 0, 3'b000, 3'b000);
    chk_a("err_clear", 3'b000, '0, 2'd0, 1'b0);

    // Full-chain stall freezes everything
    step(0, 1, 32'h300, 3'b000, 3'b000);
    step(0, 1, 32'h304, 3'b000, 3'b000);
    step(0, 1, 32'h308, 3'b000, 3'b000);
    chk_a("full2", 3'b111, {32'h300, 32'h304, 32'h308}, 2'd3, 1'b0);
    step(0, 1, 32'h400, 3'b111, 3'b111);
    chk_a("freeze", 3'b111, {32'h300, 32'h304, 32'h308}, 2'd3, 1'b0);

    // Reset overrides stall
    step(1, 1, 32'h404, 3'b111, 3'b000);
    chk_a("rst_stall", 3'b000, '0, 2'd0, 1'b0);
    chk("rst_stall.b_data", 96'(db), 96'({RV_B, RV_B, RV_B}));
    chk("rst_stall.b_occ", 96'(occb), 96'(2'd0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
